// File: rtl/accum_cmd_issuer.sv
// Command issuer for a two-lane accumulator block: queues {lane,op} commands, issues one per
// cycle, and checks the block's delayed results and halt handshake against a shadow model.
module accum_cmd_issuer #(
   parameter int unsigned LAT   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic            in_lane,
   input  logic [2:0]      in_op,
   output logic [1:0]      cmd_vld,
   output logic [1:0][2:0] opcode,
   input  logic [1:0][7:0] accum_out,
   input  logic            halt,
   output logic [1:0][7:0] exp_accum,
   output logic            mismatch,
   output logic [1:0]      err_lane,
   output logic            halted
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = $clog2(LAT + 1);
   localparam int unsigned DW = 8;

   localparam logic [2:0] OP_INCR = 3'b001;
   localparam logic [2:0] OP_DECR = 3'b010;
   localparam logic [2:0] OP_COPY = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2} state_e;
   typedef struct packed {
      logic       lane;
      logic [2:0] op;
   } cmd_t;
   typedef struct packed {
      logic               chk;
      logic [1:0][DW-1:0] exp;
   } snap_t;

   state_e             state_q, state_d;
   cmd_t               fifo_q [DEPTH];
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               in_rdy_q, in_rdy_d;
   logic [1:0]         cmd_vld_q, cmd_vld_d;
   logic [1:0][2:0]    opcode_q, opcode_d;
   logic [1:0][DW-1:0] exp_q, exp_d;
   logic               mismatch_q, mismatch_d;
   logic [1:0]         err_q, err_d;
   logic               halted_q, halted_d;
   logic [LW-1:0]      drain_cnt_q, drain_cnt_d;
   snap_t              dly_q [LAT];
   cmd_t               head;
   logic               push, pop;

   assign head = fifo_q[rd_ptr_q];
   assign push = in_vld && in_rdy_q;
   assign pop  = (state_q == S_RUN) && (count_q != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:    if (pop && head.op == OP_HALT) state_d = S_DRAIN;
         S_DRAIN:  if (drain_cnt_q == '0) state_d = S_HALTED;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RUN;
      endcase
   end

   // Issue, shadow update, result/halt checking and FIFO bookkeeping; HALTED freezes all.
   always_comb begin
      cmd_vld_d   = '0;
      opcode_d    = '0;
      exp_d       = exp_q;
      mismatch_d  = mismatch_q;
      err_d       = err_q;
      halted_d    = halted_q;
      drain_cnt_d = drain_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      if (state_q != S_HALTED) begin
         if (pop) begin
            cmd_vld_d[head.lane] = 1'b1;
            opcode_d[head.lane]  = head.op;
            case (head.op)
               OP_INCR: exp_d[head.lane] = exp_q[head.lane] + DW'(1);
               OP_DECR: exp_d[head.lane] = exp_q[head.lane] - DW'(1);
               OP_COPY: exp_d[head.lane] = exp_q[~head.lane];
               OP_HALT: drain_cnt_d      = LW'(LAT);
               default: ;
            endcase
         end
         if (dly_q[LAT-1].chk) begin
            for (int i = 0; i < 2; i++) begin
               if (accum_out[i] != dly_q[LAT-1].exp[i]) begin
                  err_d[i]   = 1'b1;
                  mismatch_d = 1'b1;
               end
            end
         end
         // Halt is only legal on the cycle the drain counter expires.
         if (state_q == S_DRAIN && drain_cnt_q == '0) begin
            halted_d = 1'b1;
            if (!halt) mismatch_d = 1'b1;
         end else if (halt) begin
            mismatch_d = 1'b1;
         end
         if (state_q == S_DRAIN && drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - LW'(1);
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
      if (state_d == S_HALTED) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
      in_rdy_d = (count_d != CW'(DEPTH)) && (state_d != S_HALTED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         in_rdy_q    <= 1'b1;
         cmd_vld_q   <= '0;
         opcode_q    <= '0;
         exp_q       <= '0;
         mismatch_q  <= 1'b0;
         err_q       <= '0;
         halted_q    <= 1'b0;
         drain_cnt_q <= '0;
         for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         in_rdy_q    <= in_rdy_d;
         cmd_vld_q   <= cmd_vld_d;
         opcode_q    <= opcode_d;
         exp_q       <= exp_d;
         mismatch_q  <= mismatch_d;
         err_q       <= err_d;
         halted_q    <= halted_d;
         drain_cnt_q <= drain_cnt_d;
         // Snapshot taken during the drive cycle lines up with accum_out LAT cycles later.
         dly_q[0] <= '{chk: |cmd_vld_q, exp: exp_q};
         for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= '{lane: in_lane, op: in_op};
   end

   assign in_rdy    = in_rdy_q;
   assign cmd_vld   = cmd_vld_q;
   assign opcode    = opcode_q;
   assign exp_accum = exp_q;
   assign mismatch  = mismatch_q;
   assign err_lane  = err_q;
   assign halted    = halted_q;
endmodule

// File: tb/tb_accum_cmd_issuer.sv
// Directed bench for accum_cmd_issuer with a behavioural LAT=4 accumulator block model.
module tb_accum_cmd_issuer;
   logic            clk;
   logic            reset_n;
   logic            in_vld;
   logic            in_rdy;
   logic            in_lane;
   logic [2:0]      in_op;
   logic [1:0]      cmd_vld;
   logic [1:0][2:0] opcode;
   logic [1:0][7:0] accum_out;
   logic            halt;
   logic [1:0][7:0] exp_accum;
   logic            mismatch;
   logic [1:0]      err_lane;
   logic            halted;

   int errors = 0;
   int checks = 0;

   logic fault1 = 1'b0;
   logic early  = 1'b0;

   accum_cmd_issuer #(.LAT(4), .DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .in_lane(in_lane), .in_op(in_op), .cmd_vld(cmd_vld), .opcode(opcode),
      .accum_out(accum_out), .halt(halt), .exp_accum(exp_accum),
      .mismatch(mismatch), .err_lane(err_lane), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator block: applies driven commands, results/halt visible 4 cycles after drive.
   logic [1:0][7:0] acc_m;
   logic [1:0][7:0] apipe [3];
   logic [3:0]      hpipe;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_m <= '0;
         for (int k = 0; k < 3; k++) apipe[k] <= '0;
         hpipe <= '0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (cmd_vld[l]) begin
               case (opcode[l])
                  3'b001:  acc_m[l] <= acc_m[l] + 8'd1;
                  3'b010:  acc_m[l] <= acc_m[l] - 8'd1;
                  3'b100:  acc_m[l] <= acc_m[1-l];
                  default: ;
               endcase
            end
         end
         hpipe <= {hpipe[2:0], (cmd_vld[0] && opcode[0] == 3'b111) ||
                               (cmd_vld[1] && opcode[1] == 3'b111)};
         apipe[0] <= acc_m;
         apipe[1] <= apipe[0];
         apipe[2] <= apipe[1];
      end
   end
   assign accum_out = {apipe[2][1] + (fault1 ? 8'd1 : 8'd0), apipe[2][0]};
   assign halt      = early ? hpipe[2] : hpipe[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
      check({tag, "_cmd_vld"}, 32'(cmd_vld), 32'd0);
      check({tag, "_opcode"}, 32'(opcode), 32'd0);
      check({tag, "_exp"}, 32'(exp_accum), 32'd0);
      check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
      check({tag, "_err"}, 32'(err_lane), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   typedef struct {
      logic       vld;
      logic       lane;
      logic [2:0] op;
      logic [1:0] e_cmd;
      logic [5:0] e_opc;
      logic [7:0] e_a0;
      logic [7:0] e_a1;
   } vec_t;
   vec_t vecs [15];

   initial begin
      // inputs | cmd_vld, {op1,op0}, exp_accum[0], exp_accum[1] seen after that edge
      vecs[0] = '{1'b1, 1'b0, 3'b001, 2'b00, 6'o00, 8'd0,   8'd0};
      vecs[1] = '{1'b1, 1'b0, 3'b001, 2'b01, 6'o01, 8'd1,   8'd0};
      vecs[2] = '{1'b1, 1'b0, 3'b001, 2'b01, 6'o01, 8'd2,   8'd0};
      vecs[3] = '{1'b1, 1'b1, 3'b010, 2'b01, 6'o01, 8'd3,   8'd0};
      vecs[4] = '{1'b1, 1'b0, 3'b100, 2'b10, 6'o20, 8'd3,   8'd255};
      vecs[5] = '{1'b1, 1'b1, 3'b001, 2'b01, 6'o04, 8'd255, 8'd255};
      vecs[6] = '{1'b0, 1'b0, 3'b000, 2'b10, 6'o10, 8'd255, 8'd0};
      vecs[7] = '{1'b1, 1'b0, 3'b011, 2'b00, 6'o00, 8'd255, 8'd0};
      vecs[8] = '{1'b0, 1'b0, 3'b000, 2'b01, 6'o03, 8'd255, 8'd0};
      for (int i = 9; i < 15; i++) vecs[i] = '{1'b0, 1'b0, 3'b000, 2'b00, 6'o00, 8'd255, 8'd0};

      in_vld  = 1'b0;
      in_lane = 1'b0;
      in_op   = 3'b000;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check_cleared("reset");

      for (int i = 0; i < 15; i++) begin
         in_vld  = vecs[i].vld;
         in_lane = vecs[i].lane;
         in_op   = vecs[i].op;
         step();
         check($sformatf("v%0d_cmd_vld", i), 32'(cmd_vld), 32'(vecs[i].e_cmd));
         check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].e_opc));
         check($sformatf("v%0d_exp0", i), 32'(exp_accum[0]), 32'(vecs[i].e_a0));
         check($sformatf("v%0d_exp1", i), 32'(exp_accum[1]), 32'(vecs[i].e_a1));
         check($sformatf("v%0d_mismatch", i), 32'(mismatch), 32'd0);
         check($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'd1);
      end

      // Correct halt at T+4; FIFO fills during drain.
      in_vld = 1'b1; in_lane = 1'b0; in_op = 3'b111;
      step();
      in_vld = 1'b0;
      step();
      check("halt_T_cmd_vld", 32'(cmd_vld), 32'b01);
      check("halt_T_opcode", 32'(opcode), 32'o07);
      in_vld = 1'b1; in_lane = 1'b1; in_op = 3'b001;
      step(); step(); step();
      check("drain_T3_in_rdy", 32'(in_rdy), 32'd1);
      step();
      check("drain_full_in_rdy", 32'(in_rdy), 32'd0);
      check("halt_T4_halted", 32'(halted), 32'd0);
      step();
      check("halt_T5_halted", 32'(halted), 32'd1);
      check("halt_T5_in_rdy", 32'(in_rdy), 32'd0);
      check("halt_T5_mismatch", 32'(mismatch), 32'd0);
      check("halt_T5_cmd_vld", 32'(cmd_vld), 32'd0);
      check("halt_T5_exp", 32'(exp_accum), 32'h00ff);
      step(); step();
      check("halted_hold", 32'(halted), 32'd1);
      check("halted_in_rdy", 32'(in_rdy), 32'd0);
      check("halted_cmd_vld", 32'(cmd_vld), 32'd0);
      in_vld = 1'b0;
      pulse_reset();
      check_cleared("rst_halted");

      // Halt arriving one cycle early.
      early = 1'b1;
      in_vld = 1'b1; in_lane = 1'b1; in_op = 3'b111;
      step();
      in_vld = 1'b0;
      step();
      check("early_T_cmd_vld", 32'(cmd_vld), 32'b10);
      check("early_T_opcode", 32'(opcode), 32'o70);
      step(); step(); step();
      check("early_T3_mismatch", 32'(mismatch), 32'd0);
      step();
      check("early_T4_mismatch", 32'(mismatch), 32'd1);
      step();
      check("early_T5_halted", 32'(halted), 32'd1);
      check("early_T5_err", 32'(err_lane), 32'd0);
      check("early_T5_mismatch", 32'(mismatch), 32'd1);
      early = 1'b0;
      pulse_reset();
      check_cleared("rst_early");

      // Lane 1 result off by one on its checked cycle.
      fault1 = 1'b1;
      in_vld = 1'b1; in_lane = 1'b1; in_op = 3'b001;
      step();
      in_vld = 1'b0;
      step();
      check("fault_D_cmd_vld", 32'(cmd_vld), 32'b10);
      check("fault_D_exp1", 32'(exp_accum[1]), 32'd1);
      repeat (4) step();
      check("fault_D4_err", 32'(err_lane), 32'b00);
      step();
      check("fault_D5_err", 32'(err_lane), 32'b10);
      check("fault_D5_mismatch", 32'(mismatch), 32'd1);
      repeat (3) step();
      check("fault_hold_err", 32'(err_lane), 32'b10);
      check("fault_hold_mismatch", 32'(mismatch), 32'd1);
      fault1 = 1'b0;
      pulse_reset();
      check_cleared("rst_fault");

      // Reset in the middle of a drain drops the pending halt check.
      in_vld = 1'b1; in_lane = 1'b0; in_op = 3'b111;
      step();
      in_vld = 1'b0;
      step(); step(); step();
      pulse_reset();
      check_cleared("rst_drain");
      repeat (8) step();
      check("post_drain_mismatch", 32'(mismatch), 32'd0);
      check("post_drain_halted", 32'(halted), 32'd0);
      check("post_drain_in_rdy", 32'(in_rdy), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
